// File: rtl/data_mem_responder_if.sv
// Processor-side request/acknowledge bus for the data memory responder.
// The master drives the request fields; the slave returns data, ack, busy and err.
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, busy, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port 32-bit data memory answering req/ack transactions after WAIT_CYCLES wait states.
// Defining MEMRESP_ADDR_CHECK_EN adds an address bounds check reported on err.
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic                 clock,
    input logic                 reset,
    data_mem_responder_if.slave bus
);
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W  = 9'(DEPTH);
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        ack_q;
    logic        busy_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        lat_we;
    logic [7:0]  lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH];

    logic        acc_we;
    logic [7:0]  acc_addr;
    logic [31:0] acc_wdata;
    logic [AW-1:0] acc_idx;
    logic        start;
    logic        access;
    logic        in_range;

    function automatic logic [AW-1:0] wrap_index(input logic [7:0] a);
        return AW'({1'b0, a} % DEPTH_W);
    endfunction

    // With no wait states the access happens on the accepting edge, so the live bus
    // fields are used there; otherwise only the latched copies are trusted.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        if (state == IDLE) begin
            acc_we    = bus.we;
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
        end
    end

    assign acc_idx = wrap_index(acc_addr);
    assign start   = (state == IDLE) && bus.req;
    assign access  = (start && NO_WAIT) || ((state == WAIT) && bus.req && (cnt == 4'd0));

`ifdef MEMRESP_ADDR_CHECK_EN
    assign in_range = ({1'b0, acc_addr} < DEPTH_W);
`else
    assign in_range = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (access) begin
                ack_q <= 1'b1;
                err_q <= ~in_range;
                if (!acc_we) begin
                    rdata_q <= in_range ? mem[acc_idx] : 32'd0;
                end
            end
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        state  <= NO_WAIT ? RESP : WAIT;
                        cnt    <= CNT_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                WAIT: begin
                    // A dropped request abandons the access before anything is committed.
                    if (!bus.req) begin
                        state  <= IDLE;
                        cnt    <= 4'd0;
                        busy_q <= 1'b0;
                    end else if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (start) begin
            lat_we    <= bus.we;
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
        end
    end

    // Memory is deliberately left out of reset; reset only gates a pending commit.
    always_ff @(posedge clock) begin
        if (reset && access && acc_we && in_range) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

    ack_single_cycle: assert property (@(posedge clock) disable iff (!reset) ack_q |=> !ack_q);
    busy_matches_state: assert property (@(posedge clock) disable iff (!reset) busy_q == (state != IDLE));
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: three configurations checked every cycle
// against a transaction-level model, plus literal checks of the handshake scenarios.
module tb_data_mem_responder;
    localparam int N    = 3;
    localparam int WC0  = 2;
    localparam int WC1  = 0;
    localparam int WC2  = 1;
    localparam int DEP2 = 16;
`ifdef MEMRESP_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        req_d  [N];
    logic        we_d   [N];
    logic [7:0]  addr_d [N];
    logic [31:0] wd_d   [N];
    logic        ack_o  [N];
    logic        busy_o [N];
    logic        err_o  [N];
    logic [31:0] rdata_o[N];

    data_mem_responder_if bus[N] ();

    for (genvar g = 0; g < N; g++) begin : g_conn
        assign bus[g].req   = req_d[g];
        assign bus[g].we    = we_d[g];
        assign bus[g].addr  = addr_d[g];
        assign bus[g].wdata = wd_d[g];
        assign ack_o[g]     = bus[g].ack;
        assign busy_o[g]    = bus[g].busy;
        assign err_o[g]     = bus[g].err;
        assign rdata_o[g]   = bus[g].rdata;
    end

    data_mem_responder #(.DEPTH(256),  .WAIT_CYCLES(WC0)) u_dut0 (.clock(clk), .reset(reset), .bus(bus[0]));
    data_mem_responder #(.DEPTH(256),  .WAIT_CYCLES(WC1)) u_dut1 (.clock(clk), .reset(reset), .bus(bus[1]));
    data_mem_responder #(.DEPTH(DEP2), .WAIT_CYCLES(WC2)) u_dut2 (.clock(clk), .reset(reset), .bus(bus[2]));

    function automatic int wc_of(input int k);
        case (k)
            0:       return WC0;
            1:       return WC1;
            default: return WC2;
        endcase
    endfunction

    function automatic int dep_of(input int k);
        return (k == 2) ? DEP2 : 256;
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Transaction-level reference: an accepted request is due WAIT_CYCLES edges later
    // unless req is seen low before then; memory is a plain array with known flags.
    int          cyc = 0;
    bit          pend   [N];
    bit          e_ack  [N];
    bit          e_busy [N];
    bit          e_err  [N];
    bit          e_rk   [N];
    bit          m_we   [N];
    int          due    [N];
    logic [7:0]  m_addr [N];
    logic [31:0] m_wd   [N];
    logic [31:0] e_rdata[N];
    logic [31:0] mm[N][256];
    bit          mk[N][256];

    function automatic void model_complete(input int k);
        bit ok;
        int idx;
        ok  = !CHK || (int'(m_addr[k]) < dep_of(k));
        idx = int'(m_addr[k]) % dep_of(k);
        pend[k]   = 1'b0;
        e_ack[k]  = 1'b1;
        e_busy[k] = 1'b1;
        e_err[k]  = !ok;
        if (m_we[k]) begin
            if (ok) begin
                mm[k][idx] = m_wd[k];
                mk[k][idx] = 1'b1;
            end
        end else if (ok) begin
            e_rdata[k] = mm[k][idx];
            e_rk[k]    = mk[k][idx];
        end else begin
            e_rdata[k] = 32'd0;
            e_rk[k]    = 1'b1;
        end
    endfunction

    function automatic void model_edge(input int k);
        if (e_ack[k]) begin
            e_ack[k]  = 1'b0;
            e_busy[k] = 1'b0;
            e_err[k]  = 1'b0;
        end else if (pend[k]) begin
            if (req_d[k] !== 1'b1) begin
                pend[k]   = 1'b0;
                e_busy[k] = 1'b0;
            end else if (cyc == due[k]) begin
                model_complete(k);
            end
        end else if (req_d[k] === 1'b1) begin
            m_we[k]   = we_d[k];
            m_addr[k] = addr_d[k];
            m_wd[k]   = wd_d[k];
            due[k]    = cyc + wc_of(k);
            pend[k]   = 1'b1;
            e_busy[k] = 1'b1;
            if (wc_of(k) == 0) model_complete(k);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            pend[k]    = 1'b0;
            e_ack[k]   = 1'b0;
            e_busy[k]  = 1'b0;
            e_err[k]   = 1'b0;
            e_rdata[k] = 32'd0;
            e_rk[k]    = 1'b1;
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!reset) model_reset();
        else for (int k = 0; k < N; k++) model_edge(k);
    end

    always @(negedge clk) begin
        if (!reset) model_reset();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("ack%0d", k), 32'(ack_o[k]), 32'(e_ack[k]));
            chk($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(e_busy[k]));
            if (e_ack[k]) chk($sformatf("err%0d", k), 32'(err_o[k]), 32'(e_err[k]));
            if (e_rk[k]) chk($sformatf("rdata%0d", k), rdata_o[k], e_rdata[k]);
        end
    end

    // Starts one phase after a rising edge and returns one phase after a rising edge.
    task automatic txn(input int k, input bit we, input logic [7:0] a, input logic [31:0] d,
                       input int abort_at, output int lat, output logic [31:0] rd, output logic er);
        lat = -1;
        rd  = 32'd0;
        er  = 1'b0;
        req_d[k]  = 1'b1;
        we_d[k]   = we;
        addr_d[k] = a;
        wd_d[k]   = d;
        @(posedge clk); #1;
        we_d[k]   = ~we;
        addr_d[k] = a ^ 8'h01;
        wd_d[k]   = ~d;
        if (abort_at >= 0) begin
            repeat (abort_at) begin @(posedge clk); #1; end
            req_d[k] = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
        end else begin
            for (int n = 1; n <= 40 && lat < 0; n++) begin
                @(negedge clk);
                if (ack_o[k] === 1'b1) begin
                    lat = n;
                    rd  = rdata_o[k];
                    er  = err_o[k];
                end
            end
            req_d[k] = 1'b0;
            if (lat < 0) begin
                total++;
                bad++;
                $display("FAIL ack_timeout%0d: got no ack, required ack within 40 cycles", k);
            end else begin
                chk($sformatf("latency%0d", k), lat, wc_of(k) + 1);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          k;
        int          ab;
        for (int i = 0; i < N; i++) begin
            req_d[i]  = 1'b0;
            we_d[i]   = 1'b0;
            addr_d[i] = 8'h00;
            wd_d[i]   = 32'd0;
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("reset_ack", 32'(ack_o[0]), 32'd0);
        chk("reset_busy", 32'(busy_o[0]), 32'd0);
        chk("reset_err", 32'(err_o[0]), 32'd0);
        chk("reset_rdata", rdata_o[0], 32'd0);

        txn(0, 1'b1, 8'h05, 32'hDEADBEEF, -1, lat, rd, er);
        chk("wr05_lat", lat, 32'd3);
        txn(0, 1'b0, 8'h05, 32'd0, -1, lat, rd, er);
        chk("rd05_lat", lat, 32'd3);
        chk("rd05_data", rd, 32'hDEADBEEF);
        chk("rd05_err", 32'(er), 32'd0);

        req_d[0] = 1'b1; we_d[0] = 1'b0; addr_d[0] = 8'h07;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_busy_wait", 32'(busy_o[0]), 32'd1);
        req_d[0] = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy_o[0]), 32'd0);
        chk("abort_ack", 32'(ack_o[0]), 32'd0);
        chk("abort_rdata", rdata_o[0], 32'hDEADBEEF);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_ack", 32'(ack_o[0]), 32'd0);
        end

        txn(0, 1'b1, 8'h03, 32'h33333333, -1, lat, rd, er);
        txn(0, 1'b1, 8'h02, 32'hA5A5A5A5, -1, lat, rd, er);
        txn(0, 1'b0, 8'h02, 32'd0, -1, lat, rd, er);
        chk("stable_rd02", rd, 32'hA5A5A5A5);
        txn(0, 1'b0, 8'h03, 32'd0, -1, lat, rd, er);
        chk("stable_rd03", rd, 32'h33333333);

        txn(0, 1'b1, 8'h10, 32'h01234567, -1, lat, rd, er);
        req_d[0] = 1'b1; we_d[0] = 1'b1; addr_d[0] = 8'h10; wd_d[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstw_busy_before", 32'(busy_o[0]), 32'd1);
        reset = 1'b0;
        req_d[0] = 1'b0;
        #1;
        chk("rstw_ack", 32'(ack_o[0]), 32'd0);
        chk("rstw_busy", 32'(busy_o[0]), 32'd0);
        chk("rstw_rdata", rdata_o[0], 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        txn(0, 1'b0, 8'h10, 32'd0, -1, lat, rd, er);
        chk("rstw_rd10", rd, 32'h01234567);

        for (int i = 0; i < 4; i++) begin
            txn(1, 1'b1, 8'(i), 32'h11111111 * (i + 1), -1, lat, rd, er);
            chk("b2b_wr_lat", lat, 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            txn(1, 1'b0, 8'(i), 32'd0, -1, lat, rd, er);
            chk("b2b_rd_lat", lat, 32'd1);
            chk("b2b_rd_data", rd, 32'h11111111 * (i + 1));
        end

        txn(2, 1'b1, 8'h00, 32'h0BADF00D, -1, lat, rd, er);
        txn(2, 1'b1, 8'h20, 32'h5555AAAA, -1, lat, rd, er);
        chk("oob_wr_err", 32'(er), 32'(CHK));
        txn(2, 1'b0, 8'h20, 32'd0, -1, lat, rd, er);
        chk("oob_rd_err", 32'(er), 32'(CHK));
        chk("oob_rd_data", rd, CHK ? 32'd0 : 32'h5555AAAA);
        txn(2, 1'b0, 8'h00, 32'd0, -1, lat, rd, er);
        chk("oob_rd00", rd, CHK ? 32'h0BADF00D : 32'h5555AAAA);
        txn(2, 1'b0, 8'h0F, 32'd0, -1, lat, rd, er);
        chk("inb_rd0f_err", 32'(er), 32'd0);

        for (int i = 0; i < 200; i++) begin
            k  = $urandom_range(0, N - 1);
            ab = -1;
            if (wc_of(k) > 0 && $urandom_range(0, 7) == 0) ab = $urandom_range(0, wc_of(k) - 1);
            txn(k, 1'($urandom_range(0, 1)), 8'($urandom_range(0, (k == 2) ? 31 : 15)),
                $urandom, ab, lat, rd, er);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
